// File: rtl/compute_ctrl_pkg.sv
// Shared types for the queued compute sequencer: FSM states and the command /
// ready-queue entry layouts (fields sized for the widest supported config).
package compute_ctrl_pkg;

    localparam int CTRL_AW_MAX = 16;
    localparam int CTRL_BW_MAX = 4;

    typedef enum logic {F_IDLE, F_WAIT} fill_state_e;
    typedef enum logic {C_IDLE, C_RUN}  comp_state_e;

    typedef struct packed {
        logic [CTRL_AW_MAX-1:0] rows;
        logic [CTRL_AW_MAX-1:0] base;
        logic                   weight_fill;
    } tile_cmd_t;

    typedef struct packed {
        logic [CTRL_AW_MAX-1:0] rows;
        logic [CTRL_AW_MAX-1:0] base;
        logic [CTRL_BW_MAX-1:0] bank;
    } ready_ent_t;

endpackage

// File: rtl/ctrl_fifo.sv
// Small synchronous FIFO with first-word fall-through read; any DEPTH >= 1.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= ptr_next(wptr);
            if (do_pop)  rptr <= ptr_next(rptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/compute_seq_ctrl.sv
// Queued compute controller: command FIFO -> fill FSM (weight bank rotation)
// -> ready queue -> compute FSM (input read + accumulator address generation).
module compute_seq_ctrl
    import compute_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WBANKS = 2,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         cmd_num_rows,
    input  logic                          cmd_weight_fill,
    input  logic [ADDR_WIDTH-1:0]         cmd_accum_base,
    output logic                          fill_start,
    output logic [$clog2(NUM_WBANKS)-1:0] fill_bank,
    input  logic                          fill_done,
    output logic                          rd_start,
    output logic [DATA_WIDTH-1:0]         rd_num_rows,
    output logic [$clog2(NUM_WBANKS)-1:0] rd_bank,
    input  logic                          psum_valid,
    output logic                          accum_wr_en,
    output logic [ADDR_WIDTH-1:0]         accum_wr_addr,
    output logic                          tile_done,
    output logic                          err_zero_rows,
    output logic                          busy
);

    localparam int BW = $clog2(NUM_WBANKS);

    tile_cmd_t   cmd_in, cmd_head;
    ready_ent_t  rq_in, rq_head;
    logic        cf_full, cf_empty, cmd_pop;
    logic        rq_full, rq_empty, rq_push, rq_pop;
    fill_state_e fstate, fstate_n;
    comp_state_e cstate, cstate_n;
    logic        fill_go, zero_go, wr_go, last_go;

    logic [BW-1:0]          fill_ptr, last_bank;
    logic [CTRL_AW_MAX-1:0] pend_rows, pend_base;
    logic [CTRL_AW_MAX-1:0] rows_q, base_q, cnt;

    assign cmd_in.rows        = CTRL_AW_MAX'(cmd_num_rows);
    assign cmd_in.base        = CTRL_AW_MAX'(cmd_accum_base);
    assign cmd_in.weight_fill = cmd_weight_fill;
    assign cmd_ready          = !cf_full;

    ctrl_fifo #(.WIDTH($bits(tile_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rstn(rstn), .push(cmd_valid && !cf_full), .wdata(cmd_in),
        .pop(cmd_pop), .rdata(cmd_head), .full(cf_full), .empty(cf_empty)
    );

    // At most NUM_WBANKS-1 tiles wait here, so a fill can never overwrite
    // the bank the compute side is reading.
    ctrl_fifo #(.WIDTH($bits(ready_ent_t)), .DEPTH(NUM_WBANKS - 1)) u_ready_q (
        .clk(clk), .rstn(rstn), .push(rq_push), .wdata(rq_in),
        .pop(rq_pop), .rdata(rq_head), .full(rq_full), .empty(rq_empty)
    );

    always_comb begin
        fstate_n = fstate;
        cmd_pop  = 1'b0;
        rq_push  = 1'b0;
        rq_in    = '0;
        fill_go  = 1'b0;
        zero_go  = 1'b0;
        case (fstate)
            F_IDLE: begin
                if (!cf_empty && !rq_full) begin
                    cmd_pop = 1'b1;
                    if (cmd_head.rows == '0) begin
                        zero_go = 1'b1;
                    end else if (cmd_head.weight_fill) begin
                        fill_go  = 1'b1;
                        fstate_n = F_WAIT;
                    end else begin
                        rq_push    = 1'b1;
                        rq_in.rows = cmd_head.rows;
                        rq_in.base = cmd_head.base;
                        rq_in.bank = CTRL_BW_MAX'(last_bank);
                    end
                end
            end
            F_WAIT: begin
                if (fill_done) begin
                    rq_push    = 1'b1;
                    rq_in.rows = pend_rows;
                    rq_in.base = pend_base;
                    rq_in.bank = CTRL_BW_MAX'(fill_ptr);
                    fstate_n   = F_IDLE;
                end
            end
            default: fstate_n = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fstate        <= F_IDLE;
            fill_ptr      <= '0;
            last_bank     <= '0;
            pend_rows     <= '0;
            pend_base     <= '0;
            fill_start    <= 1'b0;
            fill_bank     <= '0;
            err_zero_rows <= 1'b0;
        end else begin
            fstate        <= fstate_n;
            fill_start    <= fill_go;
            err_zero_rows <= zero_go;
            if (fill_go) begin
                fill_bank <= fill_ptr;
                pend_rows <= cmd_head.rows;
                pend_base <= cmd_head.base;
            end
            if (fstate == F_WAIT && fill_done) begin
                last_bank <= fill_ptr;
                fill_ptr  <= fill_ptr + BW'(1);
            end
        end
    end

    always_comb begin
        cstate_n = cstate;
        rq_pop   = 1'b0;
        wr_go    = 1'b0;
        last_go  = 1'b0;
        case (cstate)
            C_IDLE: begin
                if (!rq_empty) begin
                    rq_pop   = 1'b1;
                    cstate_n = C_RUN;
                end
            end
            C_RUN: begin
                if (psum_valid) begin
                    wr_go = 1'b1;
                    if (cnt == rows_q - CTRL_AW_MAX'(1)) begin
                        last_go  = 1'b1;
                        cstate_n = C_IDLE;
                    end
                end
            end
            default: cstate_n = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cstate        <= C_IDLE;
            rows_q        <= '0;
            base_q        <= '0;
            cnt           <= '0;
            rd_start      <= 1'b0;
            rd_num_rows   <= '0;
            rd_bank       <= '0;
            accum_wr_en   <= 1'b0;
            accum_wr_addr <= '0;
            tile_done     <= 1'b0;
        end else begin
            cstate      <= cstate_n;
            rd_start    <= rq_pop;
            accum_wr_en <= wr_go;
            tile_done   <= last_go;
            if (rq_pop) begin
                rd_bank     <= BW'(rq_head.bank);
                rd_num_rows <= DATA_WIDTH'(rq_head.rows);
                rows_q      <= rq_head.rows;
                base_q      <= rq_head.base;
                cnt         <= '0;
            end
            // Address wraps naturally by truncation to the accumulator width.
            if (wr_go) begin
                accum_wr_addr <= ADDR_WIDTH'(base_q + cnt);
                cnt           <= cnt + CTRL_AW_MAX'(1);
            end
        end
    end

    assign busy = !cf_empty || !rq_empty || (fstate != F_IDLE) || (cstate != C_IDLE);

endmodule
